regfile_write_arbiter: RTL and testbench

- Shares the single 64-bit register-file write port between two writeback requesters: A (execute/ALU result) and B (memory/load result).
- Round-robin arbitration on a valid/ready handshake; drives registered write_enable/address/data into the register file's write decoder.
- Maintains a 32-entry pending-write scoreboard so issue logic can stall on registers with outstanding writes.
- Writes to the zero register (X31) are absorbed and never reach the file.

---
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A)
// and load (B) writeback paths, with a pending-write scoreboard for issue stalls.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         a_valid,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic [DATA_WIDTH-1:0]        a_data,
  output logic                         a_ready,
  input  logic                         b_valid,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  input  logic [DATA_WIDTH-1:0]        b_data,
  output logic                         b_ready,
  input  logic                         reserve_valid,
  input  logic [ADDR_WIDTH-1:0]        reserve_addr,
  input  logic                         flush,
  input  logic [ADDR_WIDTH-1:0]        query_addr,
  output logic                         query_busy,
  output logic [(1<<ADDR_WIDTH)-1:0]   pending,
  output logic                         write_enable,
  output logic [ADDR_WIDTH-1:0]        write_addr,
  output logic [DATA_WIDTH-1:0]        write_data
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  typedef enum logic {GRANT_A, GRANT_B} grant_t;

  grant_t                  r_last_grant;
  grant_t                  w_last_grant_nxt;
  logic                    w_a_xfer;
  logic                    w_b_xfer;
  logic                    w_xfer;
  logic [ADDR_WIDTH-1:0]   w_xfer_addr;
  logic [DATA_WIDTH-1:0]   w_xfer_data;
  logic                    r_write_enable;
  logic [ADDR_WIDTH-1:0]   r_write_addr;
  logic [DATA_WIDTH-1:0]   r_write_data;
  logic [NREGS-1:0]        r_pending;
  logic [NREGS-1:0]        w_pending_nxt;

  // Ready depends only on the valids and the round-robin pointer, never on data.
  always_comb begin
    w_a_xfer         = 1'b0;
    w_b_xfer         = 1'b0;
    w_last_grant_nxt = r_last_grant;
    if (!reset && !flush) begin
      if (a_valid && (!b_valid || r_last_grant == GRANT_B)) begin
        w_a_xfer         = 1'b1;
        w_last_grant_nxt = GRANT_A;
      end else if (b_valid) begin
        w_b_xfer         = 1'b1;
        w_last_grant_nxt = GRANT_B;
      end
    end
  end

  assign a_ready     = w_a_xfer;
  assign b_ready     = w_b_xfer;
  assign w_xfer      = w_a_xfer | w_b_xfer;
  assign w_xfer_addr = w_a_xfer ? a_addr : b_addr;
  assign w_xfer_data = w_a_xfer ? a_data : b_data;

  // Clear for the accepted write is applied before the set, so a same-cycle
  // reservation of that register survives.
  always_comb begin
    w_pending_nxt = r_pending;
    if (flush) begin
      w_pending_nxt = '0;
    end else begin
      if (w_xfer)        w_pending_nxt[w_xfer_addr]  = 1'b0;
      if (reserve_valid) w_pending_nxt[reserve_addr] = 1'b1;
      w_pending_nxt[ZERO_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant   <= GRANT_B;
      r_write_enable <= 1'b0;
      r_write_addr   <= '0;
      r_write_data   <= '0;
      r_pending      <= '0;
    end else begin
      r_last_grant   <= w_last_grant_nxt;
      r_write_enable <= w_xfer && (w_xfer_addr != ZERO_IDX);
      if (w_xfer) begin
        r_write_addr <= w_xfer_addr;
        r_write_data <= w_xfer_data;
      end
      r_pending      <= w_pending_nxt;
    end
  end

  assign write_enable = r_write_enable;
  assign write_addr   = r_write_addr;
  assign write_data   = r_write_data;
  assign pending      = r_pending;
  assign query_busy   = r_pending[query_addr];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run compared against a set-based behavioural model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, reserve_valid, flush;
  logic [4:0]  a_addr, b_addr, reserve_addr, query_addr;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready, query_busy, write_enable;
  logic [31:0] pending;
  logic [4:0]  write_addr;
  logic [63:0] write_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: last winner, set of registers with outstanding writes, write port.
  bit          m_last_b;
  bit          m_busy[int];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  logic        e_a_ready, e_b_ready;

  regfile_write_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr), .flush(flush),
    .query_addr(query_addr), .query_busy(query_busy), .pending(pending),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  function automatic void model_eval();
    e_a_ready = 1'b0;
    e_b_ready = 1'b0;
    if (!reset && !flush) begin
      if (a_valid && (!b_valid || m_last_b)) e_a_ready = 1'b1;
      else if (b_valid)                      e_b_ready = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] v = '0;
    foreach (m_busy[k]) v[k] = 1'b1;
    return v;
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_last_b = 1'b1;
      m_busy.delete();
    end else begin
      if (e_a_ready) begin
        m_we = (a_addr != 5'd31); m_wa = a_addr; m_wd = a_data; m_last_b = 1'b0;
      end else if (e_b_ready) begin
        m_we = (b_addr != 5'd31); m_wa = b_addr; m_wd = b_data; m_last_b = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (flush) m_busy.delete();
      else begin
        if (e_a_ready) m_busy.delete(int'(a_addr));
        if (e_b_ready) m_busy.delete(int'(b_addr));
        if (reserve_valid && reserve_addr != 5'd31) m_busy[int'(reserve_addr)] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; reserve_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; a_valid = 1'b1; a_addr = 5'd2; b_valid = 1'b1; b_addr = 5'd3;
    settle();
    n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
    n_tests++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
    tick();
    settle();
    n_tests++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", write_enable); end
    n_tests++; if (write_addr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", write_addr); end
    n_tests++; if (write_data !== 64'd0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", write_data); end
    n_tests++; if (pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %0h expected 0", pending); end
    reset = 1'b0; idle();
    tick();
  endtask

  task automatic test_single_write();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h1234;
    settle();
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready: got %b expected 1", a_ready); end
    tick();
    idle();
    settle();
    n_tests++; if (write_enable !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b expected 1", write_enable); end
    n_tests++; if (write_addr !== 5'd5) begin n_fail++; $display("FAIL single_waddr: got %0d expected 5", write_addr); end
    n_tests++; if (write_data !== 64'h1234) begin n_fail++; $display("FAIL single_wdata: got %0h expected 1234", write_data); end
    tick();
    settle();
    n_tests++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b expected 0", write_enable); end
    n_tests++; if (write_data !== 64'h1234) begin n_fail++; $display("FAIL single_wdata_hold: got %0h expected 1234", write_data); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [63:0] ad, bd, exp_wd;
    logic [4:0]  exp_wa;
    logic        exp_a;
    reset = 1'b1; tick(); reset = 1'b0;
    ad = 64'hA0; bd = 64'hB0; exp_wa = '0; exp_wd = '0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_addr = 5'd3; a_data = ad;
      b_valid = 1'b1; b_addr = 5'd7; b_data = bd;
      settle();
      exp_a = ((i % 2) == 0);
      n_tests++; if (a_ready !== exp_a) begin n_fail++; $display("FAIL rr_a_ready[%0d]: got %b expected %b", i, a_ready, exp_a); end
      n_tests++; if (b_ready !== !exp_a) begin n_fail++; $display("FAIL rr_b_ready[%0d]: got %b expected %b", i, b_ready, !exp_a); end
      if (i > 0) begin
        n_tests++; if (write_addr !== exp_wa || write_data !== exp_wd || write_enable !== 1'b1) begin
          n_fail++; $display("FAIL rr_write[%0d]: got we=%b %0d/%0h expected we=1 %0d/%0h", i, write_enable, write_addr, write_data, exp_wa, exp_wd);
        end
      end
      if (exp_a) begin exp_wa = 5'd3; exp_wd = ad; ad = ad + 64'd1; end
      else       begin exp_wa = 5'd7; exp_wd = bd; bd = bd + 64'd1; end
      tick();
    end
    idle();
    settle();
    n_tests++; if (write_addr !== exp_wa || write_data !== exp_wd || write_enable !== 1'b1) begin
      n_fail++; $display("FAIL rr_last_write: got we=%b %0d/%0h expected we=1 %0d/%0h", write_enable, write_addr, write_data, exp_wa, exp_wd);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    a_valid = 1'b1; a_addr = 5'd31; a_data = 64'hFFFF;
    reserve_valid = 1'b1; reserve_addr = 5'd31;
    settle();
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL zero_a_ready: got %b expected 1", a_ready); end
    tick();
    idle();
    settle();
    n_tests++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL zero_we: got %b expected 0", write_enable); end
    n_tests++; if (pending !== 32'd0) begin n_fail++; $display("FAIL zero_pending: got %0h expected 0", pending); end
    tick();
  endtask

  task automatic test_scoreboard();
    query_addr = 5'd9;
    reserve_valid = 1'b1; reserve_addr = 5'd9;
    settle();
    n_tests++; if (query_busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_before: got %b expected 0", query_busy); end
    tick();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 64'h55;
    settle();
    n_tests++; if (query_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set: got %b expected 1", query_busy); end
    tick();
    reserve_valid = 1'b0; a_data = 64'h66;
    settle();
    n_tests++; if (pending[9] !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %b expected 1", pending[9]); end
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL sb_a_ready: got %b expected 1", a_ready); end
    tick();
    idle();
    settle();
    n_tests++; if (pending[9] !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %b expected 0", pending[9]); end
    n_tests++; if (query_busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_clear: got %b expected 0", query_busy); end
    n_tests++; if (write_data !== 64'h66 || write_enable !== 1'b1) begin n_fail++; $display("FAIL sb_write: got we=%b %0h expected we=1 66", write_enable, write_data); end
    tick();
  endtask

  task automatic test_flush();
    reserve_valid = 1'b1; reserve_addr = 5'd2; tick();
    reserve_addr = 5'd4; tick();
    a_valid = 1'b1; a_addr = 5'd6; a_data = 64'h77;
    flush = 1'b1; reserve_addr = 5'd10;
    settle();
    n_tests++; if (pending !== 32'h14) begin n_fail++; $display("FAIL flush_pre_pending: got %0h expected 14", pending); end
    n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL flush_a_ready: got %b expected 0", a_ready); end
    tick();
    flush = 1'b0; reserve_valid = 1'b0;
    settle();
    n_tests++; if (pending !== 32'd0) begin n_fail++; $display("FAIL flush_pending: got %0h expected 0", pending); end
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready: got %b expected 1", a_ready); end
    tick();
    idle();
    settle();
    n_tests++; if (write_enable !== 1'b1 || write_addr !== 5'd6) begin n_fail++; $display("FAIL flush_write: got we=%b %0d expected we=1 6", write_enable, write_addr); end
    tick();
  endtask

  task automatic test_reset_stall();
    b_valid = 1'b1; b_addr = 5'd12; b_data = 64'h88;
    reserve_valid = 1'b1; reserve_addr = 5'd12;
    settle();
    n_tests++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_only: got %b expected 1", b_ready); end
    tick();
    reserve_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd13; a_data = 64'h99;
    b_addr = 5'd14; b_data = 64'h111;
    settle();
    n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tie: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    tick();
    reset = 1'b1; a_valid = 1'b0;
    settle();
    n_tests++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b expected 0", b_ready); end
    n_tests++; if (pending[12] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_pending: got %b expected 1", pending[12]); end
    tick();
    reset = 1'b0;
    a_valid = 1'b1; a_addr = 5'd15; a_data = 64'h5;
    settle();
    n_tests++; if (write_enable !== 1'b0 || write_addr !== 5'd0 || write_data !== 64'd0 || pending !== 32'd0) begin
      n_fail++; $display("FAIL rst_outputs: got we=%b %0d/%0h pend=%0h expected all zero", write_enable, write_addr, write_data, pending);
    end
    n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_first_tie: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    tick();
    idle();
    settle();
    n_tests++; if (write_enable !== 1'b1 || write_addr !== 5'd15) begin n_fail++; $display("FAIL rst_after_write: got we=%b %0d expected we=1 15", write_enable, write_addr); end
    tick();
  endtask

  function automatic logic [4:0] pick_addr();
    int unsigned v = $urandom_range(0, 8);
    return (v == 8) ? 5'd31 : 5'(v);
  endfunction

  task automatic test_random();
    bit a_hold = 0, b_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!a_hold) begin a_valid = ($urandom_range(0, 2) != 0); a_addr = pick_addr(); a_data = {$urandom, $urandom}; end
      if (!b_hold) begin b_valid = ($urandom_range(0, 2) != 0); b_addr = pick_addr(); b_data = {$urandom, $urandom}; end
      reserve_valid = ($urandom_range(0, 2) == 0);
      reserve_addr  = pick_addr();
      flush         = ($urandom_range(0, 15) == 0);
      reset         = ($urandom_range(0, 63) == 0);
      query_addr    = pick_addr();
      settle();
      n_tests++; if (a_ready !== e_a_ready) begin n_fail++; $display("FAIL rnd_a_ready[%0d]: got %b expected %b", i, a_ready, e_a_ready); end
      n_tests++; if (b_ready !== e_b_ready) begin n_fail++; $display("FAIL rnd_b_ready[%0d]: got %b expected %b", i, b_ready, e_b_ready); end
      n_tests++; if (write_enable !== m_we) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b expected %b", i, write_enable, m_we); end
      n_tests++; if (write_addr !== m_wa) begin n_fail++; $display("FAIL rnd_waddr[%0d]: got %0d expected %0d", i, write_addr, m_wa); end
      n_tests++; if (write_data !== m_wd) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %0h expected %0h", i, write_data, m_wd); end
      n_tests++; if (pending !== model_pending()) begin n_fail++; $display("FAIL rnd_pending[%0d]: got %0h expected %0h", i, pending, model_pending()); end
      n_tests++; if (query_busy !== m_busy.exists(int'(query_addr))) begin
        n_fail++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, query_busy, m_busy.exists(int'(query_addr)));
      end
      a_hold = a_valid && !e_a_ready && !reset;
      b_hold = b_valid && !e_b_ready && !reset;
      tick();
    end
    reset = 1'b0; idle();
    tick();
  endtask

  initial begin
    reset = 1'b1; idle();
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    reserve_addr = '0; query_addr = '0;
    m_last_b = 1'b1; m_we = 1'b0; m_wa = '0; m_wd = '0;
    @(posedge clk); #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_reset_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
